fir_decim_requant: RTL and testbench

Downstream stage of the FIR filter. It accepts the filter's 32-bit signed AXI-Stream output, keeps one sample in every DECIM, and rounds, shifts and saturates the kept sample to a 16-bit signed stream. Frame boundaries (tlast) and back-pressure pass through without loss or duplication. It sits between the FIR output and the DAC/packetiser, and reduces the sample rate and word width for later stages.

---
 rtl/fir_pkg.sv | 33 +++
 rtl/axis_pipe_stage.sv | 31 +++
 rtl/fir_decim_requant.sv | 91 +++++++++
 tb/tb_fir_decim_requant.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, saturation limits and the round/shift/saturate helper for the
// FIR decimating requantiser.
package fir_pkg;

    localparam int OUT_W = 16;
    localparam int IN_W  = 32;

    localparam logic signed [OUT_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [OUT_W-1:0] SAT_MIN = 16'sh8000;

    // Limits widened to the rounding width so comparisons stay signed.
    localparam logic signed [IN_W:0] SAT_MAX_X = (IN_W + 1)'(SAT_MAX);
    localparam logic signed [IN_W:0] SAT_MIN_X = (IN_W + 1)'(SAT_MIN);

    // Round half toward +inf, arithmetic shift right, clip to OUT_W bits.
    // Returns {sat, y}; sat is set when clipping happened.
    function automatic logic [OUT_W:0] round_sat(input logic signed [IN_W-1:0] x,
                                                 input int unsigned shift);
        logic signed [IN_W:0] bias;
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] y;
        bias = $signed((IN_W + 1)'(1) << (shift - 1));
        sum  = $signed({x[IN_W-1], x}) + bias;
        y    = sum >>> shift;
        if (y > SAT_MAX_X) begin
            return {1'b1, SAT_MAX};
        end else if (y < SAT_MIN_X) begin
            return {1'b1, SAT_MIN};
        end
        return {1'b0, y[OUT_W-1:0]};
    endfunction

endpackage

// File: rtl/axis_pipe_stage.sv
// One valid/ready register slice: loads when empty or when its consumer takes
// the held word, and holds data stable while stalled.
module axis_pipe_stage #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    assign in_ready = !out_valid || out_ready;

    // Register slice; an idle upstream cycle empties the slot once it drains.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/fir_decim_requant.sv
// Keeps one FIR output sample in every DECIM (or at frame end), requantises
// it to 16 bits and forwards it through a two-register AXI-Stream pipeline.
module fir_decim_requant
    import fir_pkg::*;
#(
    parameter int unsigned DECIM = 4,
    parameter int unsigned SHIFT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   s_axis_dec_tdata,
    input  logic [3:0]        s_axis_dec_tkeep,
    input  logic              s_axis_dec_tlast,
    input  logic              s_axis_dec_tvalid,
    output logic              s_axis_dec_tready,
    output logic [OUT_W-1:0]  m_axis_dec_tdata,
    output logic [1:0]        m_axis_dec_tkeep,
    output logic              m_axis_dec_tlast,
    output logic              m_axis_dec_tvalid,
    input  logic              m_axis_dec_tready,
    output logic              sat_flag
);

    localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0] phase;
    logic            in_xfer;
    logic            keep;
    logic [OUT_W:0]  rs;       // {sat, y}
    logic [OUT_W:0]  a_in;     // {last, y}
    logic [OUT_W:0]  a_out;
    logic [OUT_W:0]  b_out;
    logic            a_valid;
    logic            b_in_ready;
    logic            unused_tkeep;

    assign unused_tkeep = ^s_axis_dec_tkeep;

    assign in_xfer = s_axis_dec_tvalid && s_axis_dec_tready;
    // tlast closes the group early so each frame starts a fresh group.
    assign keep    = (phase == PH_LAST) || s_axis_dec_tlast;
    assign rs      = round_sat(s_axis_dec_tdata, SHIFT);
    assign a_in    = {s_axis_dec_tlast, rs[OUT_W-1:0]};

    // Phase counter: advances per accepted sample, restarts after a kept one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= '0;
        end else if (in_xfer) begin
            phase <= keep ? '0 : phase + 1'b1;
        end
    end

    // Sticky saturation flag, raised as the clipped sample enters stage A.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_flag <= 1'b0;
        end else if (in_xfer && keep && rs[OUT_W]) begin
            sat_flag <= 1'b1;
        end
    end

    // Discarded samples are still accepted but load an empty slot.
    axis_pipe_stage #(.W(OUT_W + 1)) u_stage_a (
        .clk       (clk),
        .reset     (reset),
        .in_data   (a_in),
        .in_valid  (s_axis_dec_tvalid && keep),
        .in_ready  (s_axis_dec_tready),
        .out_data  (a_out),
        .out_valid (a_valid),
        .out_ready (b_in_ready)
    );

    axis_pipe_stage #(.W(OUT_W + 1)) u_stage_b (
        .clk       (clk),
        .reset     (reset),
        .in_data   (a_out),
        .in_valid  (a_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out),
        .out_valid (m_axis_dec_tvalid),
        .out_ready (m_axis_dec_tready)
    );

    assign m_axis_dec_tdata = b_out[OUT_W-1:0];
    assign m_axis_dec_tlast = b_out[OUT_W];
    assign m_axis_dec_tkeep = {2{m_axis_dec_tvalid}};

endmodule

// File: tb/tb_fir_decim_requant.sv
// Bench for fir_decim_requant: a DECIM=1 and a DECIM=4 instance, checked
// against an arithmetic model of keep/round/shift/saturate.
module tb_fir_decim_requant;

    localparam int unsigned SHIFT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [31:0] s1_data;  logic [3:0] s1_keep;  logic s1_last, s1_valid, s1_ready;
    logic [15:0] m1_data;  logic [1:0] m1_keep;  logic m1_last, m1_valid, m1_ready, sat1;
    logic [31:0] s4_data;  logic [3:0] s4_keep;  logic s4_last, s4_valid, s4_ready;
    logic [15:0] m4_data;  logic [1:0] m4_keep;  logic m4_last, m4_valid, m4_ready, sat4;

    int checks = 0;
    int errors = 0;

    fir_decim_requant #(.DECIM(1), .SHIFT(SHIFT)) u_dut1 (
        .clk               (clk),
        .reset             (rst_n),
        .s_axis_dec_tdata  (s1_data),
        .s_axis_dec_tkeep  (s1_keep),
        .s_axis_dec_tlast  (s1_last),
        .s_axis_dec_tvalid (s1_valid),
        .s_axis_dec_tready (s1_ready),
        .m_axis_dec_tdata  (m1_data),
        .m_axis_dec_tkeep  (m1_keep),
        .m_axis_dec_tlast  (m1_last),
        .m_axis_dec_tvalid (m1_valid),
        .m_axis_dec_tready (m1_ready),
        .sat_flag          (sat1)
    );

    fir_decim_requant #(.DECIM(4), .SHIFT(SHIFT)) u_dut4 (
        .clk               (clk),
        .reset             (rst_n),
        .s_axis_dec_tdata  (s4_data),
        .s_axis_dec_tkeep  (s4_keep),
        .s_axis_dec_tlast  (s4_last),
        .s_axis_dec_tvalid (s4_valid),
        .s_axis_dec_tready (s4_ready),
        .m_axis_dec_tdata  (m4_data),
        .m_axis_dec_tkeep  (m4_keep),
        .m_axis_dec_tlast  (m4_last),
        .m_axis_dec_tvalid (m4_valid),
        .m_axis_dec_tready (m4_ready),
        .sat_flag          (sat4)
    );

    // Reference: real-valued rounding done on a wide integer, then clipped.
    function automatic logic [15:0] ref_q(input logic [31:0] x, output bit sat);
        longint v;
        v = (longint'($signed(x)) + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        sat = (v > 32767) || (v < -32768);
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    task automatic set_idle();
        s1_data = '0; s1_keep = 4'hF; s1_last = 1'b0; s1_valid = 1'b0; m1_ready = 1'b1;
        s4_data = '0; s4_keep = 4'hF; s4_last = 1'b0; s4_valid = 1'b0; m4_ready = 1'b1;
    endtask

    // Leaves time at 1 unit after a rising edge with reset released.
    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({m1_valid, m1_data, m1_last, m1_keep, sat1} !== 21'd0) begin
            errors++;
            $display("FAIL reset_out1 got v=%b d=%h l=%b k=%b s=%b exp all 0",
                     m1_valid, m1_data, m1_last, m1_keep, sat1);
        end
        checks++;
        if ({m4_valid, m4_data, m4_last, m4_keep, sat4} !== 21'd0) begin
            errors++;
            $display("FAIL reset_out4 got v=%b d=%h l=%b k=%b s=%b exp all 0",
                     m4_valid, m4_data, m4_last, m4_keep, sat4);
        end
        checks++;
        if (s1_ready !== 1'b1 || s4_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b/%b exp 1/1", s1_ready, s4_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_requant();
        logic [31:0] vin [5];
        logic [15:0] ev;
        bit s, sat_seen;
        vin = '{32'h3FFF8000, 32'h40000000, 32'hC0000000, 32'h00004000, 32'hFFFFC000};
        do_reset();
        sat_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            s1_valid = (c < 5);
            s1_data  = '0;
            if (c < 5) s1_data = vin[c];
            @(negedge clk);
            if (c >= 2 && c < 7) begin
                ev = ref_q(vin[c-2], s);
                checks++;
                if (m1_valid !== 1'b1 || m1_data !== ev || m1_last !== 1'b0
                    || m1_keep !== 2'b11) begin
                    errors++;
                    $display("FAIL requant_out c=%0d got v=%b d=%h k=%b exp v=1 d=%h k=11",
                             c, m1_valid, m1_data, m1_keep, ev);
                end
            end else begin
                checks++;
                if (m1_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL requant_idle c=%0d got v=%b exp 0", c, m1_valid);
                end
            end
            // Sample c-1 entered stage A at the last edge.
            if (c >= 1 && c <= 5) begin
                void'(ref_q(vin[c-1], s));
                sat_seen = sat_seen | s;
            end
            checks++;
            if (sat1 !== sat_seen) begin
                errors++;
                $display("FAIL requant_sat c=%0d got %b exp %b", c, sat1, sat_seen);
            end
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    task automatic test_decimate();
        logic [31:0] vin [$];
        bit lst [$];
        bit kept [$];
        int n, cnt, j;
        logic [15:0] ev;
        bit s;
        for (int sc = 0; sc < 2; sc++) begin
            do_reset();
            n = (sc == 0) ? 8 : 10;
            vin.delete(); lst.delete(); kept.delete();
            cnt = 0;
            for (int k = 1; k <= n; k++) begin
                vin.push_back(32'(k << 15));
                lst.push_back(sc == 1 && k == 6);
                cnt++;
                kept.push_back(cnt == 4 || lst[k-1]);
                if (kept[k-1]) cnt = 0;
            end
            for (int c = 0; c < n + 3; c++) begin
                s4_valid = (c < n);
                s4_data  = '0;
                s4_last  = 1'b0;
                if (c < n) begin
                    s4_data = vin[c];
                    s4_last = lst[c];
                end
                @(negedge clk);
                checks++;
                if (s4_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL decim_ready sc=%0d c=%0d got %b exp 1", sc, c, s4_ready);
                end
                j = c - 2;
                checks++;
                if (j >= 0 && j < n && kept[j]) begin
                    ev = ref_q(vin[j], s);
                    if (m4_valid !== 1'b1 || m4_data !== ev || m4_last !== lst[j]
                        || m4_keep !== 2'b11) begin
                        errors++;
                        $display("FAIL decim_out sc=%0d c=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                 sc, c, m4_valid, m4_data, m4_last, ev, lst[j]);
                    end
                end else if (m4_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL decim_idle sc=%0d c=%0d got v=%b d=%h exp v=0",
                             sc, c, m4_valid, m4_data);
                end
                @(posedge clk); #1;
            end
        end
        set_idle();
    endtask

    task automatic test_back_pressure();
        logic [15:0] expq [$];
        logic [15:0] held;
        bit stalled, s;
        int sent, got;
        do_reset();
        for (int k = 1; k <= 20; k++) expq.push_back(ref_q(32'(k << 15), s));
        stalled = 1'b0; sent = 0; got = 0; held = '0;
        for (int c = 0; c < 300 && got < 20; c++) begin
            if (c < 5) m1_ready = 1'b1;
            else if (c <= 9) m1_ready = 1'b0;
            else m1_ready = 1'($urandom_range(0, 1));
            s1_valid = (sent < 20);
            s1_data  = 32'((sent + 1) << 15);
            @(negedge clk);
            if (c >= 6 && c <= 9) begin
                checks++;
                if (s1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready_low c=%0d got %b exp 0", c, s1_ready);
                end
            end
            if (stalled) begin
                checks++;
                if (m1_valid !== 1'b1 || m1_data !== held) begin
                    errors++;
                    $display("FAIL bp_stable c=%0d got v=%b d=%h exp v=1 d=%h",
                             c, m1_valid, m1_data, held);
                end
            end
            if (m1_valid && m1_ready) begin
                checks++;
                if (m1_data !== expq[got]) begin
                    errors++;
                    $display("FAIL bp_data n=%0d got %h exp %h", got, m1_data, expq[got]);
                end
                got++;
            end
            stalled = m1_valid && !m1_ready;
            held = m1_data;
            if (s1_valid && s1_ready) sent++;
            @(posedge clk); #1;
        end
        checks++;
        if (got != 20) begin
            errors++;
            $display("FAIL bp_count got %0d outputs exp 20", got);
        end
        set_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (m1_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_extra c=%0d got v=%b d=%h exp v=0", c, m1_valid, m1_data);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [16:0] expq [$];  // {last, data}
        logic [16:0] held;
        logic [15:0] y;
        bit stalled, s, sat_model, k;
        int cnt, got;
        do_reset();
        cnt = 0; got = 0; stalled = 1'b0; sat_model = 1'b0; held = '0;
        for (int c = 0; c < 460; c++) begin
            if (c < 400) begin
                s4_valid = ($urandom_range(0, 3) != 0);
                s4_data  = $urandom;
                if ($urandom_range(0, 3) != 0) s4_data = {{10{s4_data[31]}}, s4_data[31:10]};
                s4_last  = ($urandom_range(0, 7) == 0);
                m4_ready = ($urandom_range(0, 9) < 7);
            end else begin
                s4_valid = 1'b0;
                m4_ready = 1'b1;
            end
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (m4_valid !== 1'b1 || {m4_last, m4_data} !== held) begin
                    errors++;
                    $display("FAIL rnd_stable c=%0d got v=%b %h exp v=1 %h",
                             c, m4_valid, {m4_last, m4_data}, held);
                end
            end
            if (m4_valid && m4_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_unexpected c=%0d got %h exp none", c, {m4_last, m4_data});
                end else begin
                    if ({m4_last, m4_data} !== expq[0] || m4_keep !== 2'b11) begin
                        errors++;
                        $display("FAIL rnd_data c=%0d got %h k=%b exp %h k=11",
                                 c, {m4_last, m4_data}, m4_keep, expq[0]);
                    end
                    void'(expq.pop_front());
                end
                got++;
            end
            stalled = m4_valid && !m4_ready;
            held = {m4_last, m4_data};
            if (s4_valid && s4_ready) begin
                cnt++;
                k = (cnt == 4) || s4_last;
                if (k) begin
                    y = ref_q(s4_data, s);
                    sat_model = sat_model | s;
                    expq.push_back({s4_last, y});
                    cnt = 0;
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (expq.size() != 0 || got == 0) begin
            errors++;
            $display("FAIL rnd_drain got %0d left %0d outputs exp 0 left", got, expq.size());
        end
        checks++;
        if (sat4 !== sat_model) begin
            errors++;
            $display("FAIL rnd_sat got %b exp %b", sat4, sat_model);
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] vin [6];
        logic [15:0] ev;
        bit s;
        do_reset();
        for (int j = 0; j < 6; j++) vin[j] = 32'((j + 1) << 15);
        vin[3] = 32'h7FFFFFFF;
        for (int c = 0; c < 6; c++) begin
            s4_valid = 1'b1;
            s4_data  = vin[c];
            m4_ready = (c < 5);
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (m4_valid !== 1'b1 || sat4 !== 1'b1) begin
                    errors++;
                    $display("FAIL rmid_pending got v=%b sat=%b exp v=1 sat=1", m4_valid, sat4);
                end
            end
            @(posedge clk); #1;
        end
        s4_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m4_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({m4_valid, m4_data, m4_last, m4_keep, sat4} !== 21'd0 || s4_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_after got v=%b d=%h l=%b k=%b s=%b rdy=%b exp zeros rdy=1",
                     m4_valid, m4_data, m4_last, m4_keep, sat4, s4_ready);
        end
        @(posedge clk); #1;
        for (int j = 0; j < 6; j++) vin[j] = 32'((j + 50) << 15);
        for (int c = 0; c < 8; c++) begin
            s4_valid = (c < 6);
            s4_data  = '0;
            if (c < 6) s4_data = vin[c];
            @(negedge clk);
            checks++;
            if (c == 5) begin
                ev = ref_q(vin[3], s);
                if (m4_valid !== 1'b1 || m4_data !== ev) begin
                    errors++;
                    $display("FAIL rmid_first got v=%b d=%h exp v=1 d=%h", m4_valid, m4_data, ev);
                end
            end else if (m4_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_idle c=%0d got v=%b d=%h exp v=0", c, m4_valid, m4_data);
            end
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_requant();
        test_decimate();
        test_back_pressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
